// File: rtl/store_packer_if.sv
// store_packer_if: request, packed-write and error signals of the store packer
interface store_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [3:0]  out_be;
  logic [31:0] out_data;
  logic        err_valid;
  logic [31:0] err_addr;
  modport master (
    output in_valid, in_addr, in_data, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_be, out_data, err_valid, err_addr
  );
  modport slave (
    input  in_valid, in_addr, in_data, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_be, out_data, err_valid, err_addr
  );
endinterface

// File: rtl/store_packer.sv
// store_packer: aligns sw/sh/sb stores into byte-enabled word writes through a small FIFO
module store_packer #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  store_packer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [3:0]    be_q [DEPTH];
  logic [3:0]    be_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic          acc, legal, push, pop;
  logic [1:0]    a, sz;
  logic [31:0]   d, pk_data;
  logic [3:0]    pk_be;
  // reset gates in_ready so nothing is accepted while it is asserted
  assign bus.in_ready  = !reset && cnt_q != FULL;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_addr  = bus.out_valid ? addr_q[rd_q] : '0;
  assign bus.out_be    = bus.out_valid ? be_q[rd_q] : '0;
  assign bus.out_data  = bus.out_valid ? data_q[rd_q] : '0;
  assign bus.err_valid = err_q;
  assign bus.err_addr  = err_addr_q;
  assign a  = bus.in_addr[1:0];
  assign sz = bus.in_size;
  assign d  = bus.in_data;
  // lane alignment, legality check, and FIFO/error next state
  always_comb begin
    legal   = (sz == 2'd0 && a == 2'd0) || (sz == 2'd1 && !a[0]) || sz == 2'd2;
    pk_be   = sz == 2'd0 ? 4'hf : sz == 2'd1 ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a;
    pk_data = sz == 2'd0 ? d : sz == 2'd1 ? (a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]})
                         : {24'h0, d[7:0]} << {a, 3'b000};
    acc     = bus.in_valid && bus.in_ready;
    push    = acc && legal;
    pop     = bus.out_valid && bus.out_ready;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    if (push) begin
      addr_d[wr_q] = {bus.in_addr[31:2], 2'b00};
      be_d[wr_q]   = pk_be;
      data_d[wr_q] = pk_data;
    end
    err_d      = acc && !legal;
    err_addr_d = err_d ? bus.in_addr : err_addr_q;
  end
  // state registers; asynchronous reset discards every queued entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        be_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      data_q     <= data_d;
    end
  end
endmodule
